// File: rtl/debug_probe_bank.sv
// debug_probe_bank: frame-strobed capture of CH_NUM probe channels, paged onto SLOT_NUM display slots.
// Defining DEBUG_PROBE_PEAK_EN adds a per-channel peak hold, which makes clr_btn and peak_view active.
module debug_probe_bank #(
  parameter int                IN_W      = 17,
  parameter int                SEQ_LEN   = 20,
  parameter int                CH_NUM    = 8,
  parameter int                SLOT_NUM  = 6,
  parameter int                PAGE_W    = 4,
  parameter logic [CH_NUM-1:0] SIGNED_CH = {CH_NUM{1'b1}}
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic [CH_NUM*IN_W-1:0]      probe_in,
  input  logic                        sample_tick,
  input  logic                        page_btn,
  input  logic                        freeze_btn,
  input  logic                        clr_btn,
  input  logic                        peak_view,
  output logic [SLOT_NUM*SEQ_LEN-1:0] seq_out,
  output logic [PAGE_W-1:0]           page_idx,
  output logic                        frozen,
  output logic                        update_pulse
);

  localparam int                PAGE_NUM  = (CH_NUM + SLOT_NUM - 1) / SLOT_NUM;
  localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(PAGE_NUM - 1);

  generate
    if (SEQ_LEN < IN_W) begin : g_bad_seq_len
      $error("debug_probe_bank: SEQ_LEN must not be smaller than IN_W");
    end
    if (PAGE_NUM > (1 << PAGE_W)) begin : g_bad_page_w
      $error("debug_probe_bank: PAGE_W too narrow for the number of pages");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_LIVE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic                        r_page_prev;
  logic                        r_frz_prev;
  logic                        w_page_edge;
  logic                        w_frz_edge;
  logic                        w_capture;
  logic                        w_view_reload;
  logic                        w_reload;
  logic [PAGE_W-1:0]           r_page;
  logic [PAGE_W-1:0]           w_page_nxt;
  logic [IN_W-1:0]             r_cap     [CH_NUM];
  logic [IN_W-1:0]             w_cap_nxt [CH_NUM];
  logic [IN_W-1:0]             w_view    [CH_NUM];
  logic [SLOT_NUM*SEQ_LEN-1:0] w_slots;
  logic [SLOT_NUM*SEQ_LEN-1:0] r_seq;
  logic                        r_pulse;
  logic                        r_frozen;

  function automatic logic [SEQ_LEN-1:0] extend(input logic [IN_W-1:0] v, input logic sgn);
    logic [SEQ_LEN-1:0] r;
    r           = {SEQ_LEN{sgn & v[IN_W-1]}};
    r[IN_W-1:0] = v;
    return r;
  endfunction

  assign w_page_edge = page_btn & ~r_page_prev;
  assign w_frz_edge  = freeze_btn & ~r_frz_prev;

  // Button history for edge detection
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_page_prev <= 1'b0;
      r_frz_prev  <= 1'b0;
    end else begin
      r_page_prev <= page_btn;
      r_frz_prev  <= freeze_btn;
    end
  end

  // Freeze FSM: PEND grabs exactly one more frame before locking the bank
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      ST_LIVE: begin
        w_capture = sample_tick;
        if (w_frz_edge) w_state_nxt = ST_PEND;
        else            w_state_nxt = ST_LIVE;
      end
      ST_PEND: begin
        w_capture = sample_tick;
        if (w_frz_edge)       w_state_nxt = ST_LIVE;
        else if (sample_tick) w_state_nxt = ST_FROZEN;
        else                  w_state_nxt = ST_PEND;
      end
      ST_FROZEN: begin
        w_capture = 1'b0;
        if (w_frz_edge) w_state_nxt = ST_LIVE;
        else            w_state_nxt = ST_FROZEN;
      end
      default: begin
        w_capture   = 1'b0;
        w_state_nxt = ST_LIVE;
      end
    endcase
  end

  always_comb begin
    w_page_nxt = r_page;
    if (w_page_edge) begin
      if (r_page == LAST_PAGE) w_page_nxt = {PAGE_W{1'b0}};
      else                     w_page_nxt = r_page + PAGE_W'(1'b1);
    end else begin
      w_page_nxt = r_page;
    end
  end

  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
      w_cap_nxt[c] = w_capture ? probe_in[c*IN_W +: IN_W] : r_cap[c];
    end
  end

  // State, page and capture bank
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_LIVE;
      r_page  <= {PAGE_W{1'b0}};
      for (int c = 0; c < CH_NUM; c++) r_cap[c] <= {IN_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_page  <= w_page_nxt;
      for (int c = 0; c < CH_NUM; c++) r_cap[c] <= w_cap_nxt[c];
    end
  end

`ifdef DEBUG_PROBE_PEAK_EN
  logic            r_clr_prev;
  logic            r_view_prev;
  logic            w_clr_edge;
  logic [IN_W-1:0] r_peak      [CH_NUM];
  logic [IN_W-1:0] w_peak_base [CH_NUM];
  logic [IN_W-1:0] w_peak_nxt  [CH_NUM];

  function automatic logic [IN_W-1:0] peak_floor(input logic sgn);
    return {sgn, {(IN_W-1){1'b0}}};
  endfunction

  function automatic logic above(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b, input logic sgn);
    return sgn ? ($signed(a) > $signed(b)) : (a > b);
  endfunction

  assign w_clr_edge    = clr_btn & ~r_clr_prev;
  assign w_view_reload = w_clr_edge | (peak_view ^ r_view_prev);

  // A clear that coincides with a capture restarts tracking from the new sample
  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
      w_peak_base[c] = w_clr_edge ? peak_floor(SIGNED_CH[c]) : r_peak[c];
      w_peak_nxt[c]  = (w_capture && above(w_cap_nxt[c], w_peak_base[c], SIGNED_CH[c]))
                       ? w_cap_nxt[c] : w_peak_base[c];
      w_view[c]      = peak_view ? w_peak_nxt[c] : w_cap_nxt[c];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_clr_prev  <= 1'b0;
      r_view_prev <= 1'b0;
      for (int c = 0; c < CH_NUM; c++) r_peak[c] <= peak_floor(SIGNED_CH[c]);
    end else begin
      r_clr_prev  <= clr_btn;
      r_view_prev <= peak_view;
      for (int c = 0; c < CH_NUM; c++) r_peak[c] <= w_peak_nxt[c];
    end
  end
`else
  logic w_unused_ok;
  assign w_unused_ok   = clr_btn ^ peak_view;
  assign w_view_reload = 1'b0;

  always_comb begin
    for (int c = 0; c < CH_NUM; c++) w_view[c] = w_cap_nxt[c];
  end
`endif

  assign w_reload = w_capture | w_page_edge | w_view_reload;

  // Slot s maps to channel page*SLOT_NUM+s; out-of-range slots stay zero
  always_comb begin
    w_slots = {(SLOT_NUM*SEQ_LEN){1'b0}};
    for (int s = 0; s < SLOT_NUM; s++) begin
      for (int c = 0; c < CH_NUM; c++) begin
        w_slots[s*SEQ_LEN +: SEQ_LEN] = w_slots[s*SEQ_LEN +: SEQ_LEN] |
          (((int'(w_page_nxt) * SLOT_NUM + s) == c) ? extend(w_view[c], SIGNED_CH[c])
                                                     : {SEQ_LEN{1'b0}});
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_seq    <= {(SLOT_NUM*SEQ_LEN){1'b0}};
      r_pulse  <= 1'b0;
      r_frozen <= 1'b0;
    end else begin
      r_pulse  <= w_reload;
      r_frozen <= (w_state_nxt == ST_FROZEN);
      if (w_reload) r_seq <= w_slots;
      else          r_seq <= r_seq;
    end
  end

  assign seq_out      = r_seq;
  assign page_idx     = r_page;
  assign frozen       = r_frozen;
  assign update_pulse = r_pulse;

endmodule

// File: tb/tb_debug_probe_bank.sv
// Self-checking bench for debug_probe_bank: directed sequences, a vector table and randomized
// traffic compared against a behavioural model; two instances differ only in SIGNED_CH bit 0.
module tb_debug_probe_bank;
  localparam int IN_W     = 17;
  localparam int SEQ_LEN  = 20;
  localparam int CH_NUM   = 8;
  localparam int SLOT_NUM = 6;
  localparam int PAGE_W   = 4;
  localparam int PAGE_NUM = 2;
  localparam int SEQ_BITS = SLOT_NUM * SEQ_LEN;

  logic                     sys_clk;
  logic                     sys_rst_n;
  logic [CH_NUM*IN_W-1:0]   probe_in;
  logic                     sample_tick, page_btn, freeze_btn, clr_btn, peak_view;
  logic [SEQ_BITS-1:0]      seq_out, seq_out_u;
  logic [PAGE_W-1:0]        page_idx, page_idx_u;
  logic                     frozen, frozen_u, update_pulse, update_pulse_u;
  int                       n_checks;
  int                       n_errors;

  debug_probe_bank #(.SIGNED_CH(8'hFF)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .probe_in(probe_in), .sample_tick(sample_tick),
    .page_btn(page_btn), .freeze_btn(freeze_btn), .clr_btn(clr_btn), .peak_view(peak_view),
    .seq_out(seq_out), .page_idx(page_idx), .frozen(frozen), .update_pulse(update_pulse));

  debug_probe_bank #(.SIGNED_CH(8'hFE)) dut_u (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .probe_in(probe_in), .sample_tick(sample_tick),
    .page_btn(page_btn), .freeze_btn(freeze_btn), .clr_btn(clr_btn), .peak_view(peak_view),
    .seq_out(seq_out_u), .page_idx(page_idx_u), .frozen(frozen_u), .update_pulse(update_pulse_u));

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Behavioural model: instance 0 is fully signed, instance 1 has channel 0 unsigned
  logic [IN_W-1:0]     m_cap  [CH_NUM];
  logic [IN_W-1:0]     m_peak [2][CH_NUM];
  logic [SEQ_BITS-1:0] m_seq  [2];
  int                  m_page;
  bit                  m_pend, m_frz, m_pulse, m_pp, m_fp, m_cp, m_vp;

  function automatic logic [7:0] mask_of(int k);
    return (k == 0) ? 8'hFF : 8'hFE;
  endfunction

  function automatic int as_int(logic [IN_W-1:0] v, bit sgn);
    return sgn ? int'($signed(v)) : int'(v);
  endfunction

  function automatic logic [IN_W-1:0] lowest(bit sgn);
    int mn;
    mn = sgn ? -(1 << (IN_W - 1)) : 0;
    return mn[IN_W-1:0];
  endfunction

  function automatic logic [SEQ_BITS-1:0] build(int k, bit view);
    logic [SEQ_BITS-1:0] r;
    logic [7:0]          mk;
    logic [31:0]         y;
    int                  ch;
    r  = '0;
    mk = mask_of(k);
    for (int s = 0; s < SLOT_NUM; s++) begin
      ch = m_page * SLOT_NUM + s;
      if (ch < CH_NUM) begin
        y = as_int(view ? m_peak[k][ch] : m_cap[ch], mk[ch]);
        r[s*SEQ_LEN +: SEQ_LEN] = y[SEQ_LEN-1:0];
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    logic [7:0] mk;
    for (int k = 0; k < 2; k++) begin
      mk = mask_of(k);
      m_seq[k] = '0;
      for (int c = 0; c < CH_NUM; c++) m_peak[k][c] = lowest(mk[c]);
    end
    for (int c = 0; c < CH_NUM; c++) m_cap[c] = '0;
    m_page = 0; m_pend = 1'b0; m_frz = 1'b0; m_pulse = 1'b0;
    m_pp = 1'b0; m_fp = 1'b0; m_cp = 1'b0; m_vp = 1'b0;
  endtask

  task automatic model_step();
    bit              pe, fe, cap, reload, view;
    logic [IN_W-1:0] v;
    pe  = page_btn && !m_pp;
    fe  = freeze_btn && !m_fp;
    cap = sample_tick && !m_frz;
    if (m_frz) begin
      if (fe) m_frz = 1'b0;
    end else if (m_pend) begin
      if (fe) m_pend = 1'b0;
      else if (sample_tick) begin m_pend = 1'b0; m_frz = 1'b1; end
    end else if (fe) begin
      m_pend = 1'b1;
    end
    reload = cap || pe;
    view   = 1'b0;
    for (int c = 0; c < CH_NUM; c++) begin
      v = probe_in[c*IN_W +: IN_W];
      if (cap) m_cap[c] = v;
    end
`ifdef DEBUG_PROBE_PEAK_EN
    begin
      bit         ce;
      logic [7:0] mk;
      ce = clr_btn && !m_cp;
      for (int k = 0; k < 2; k++) begin
        mk = mask_of(k);
        for (int c = 0; c < CH_NUM; c++) begin
          if (ce) m_peak[k][c] = lowest(mk[c]);
          if (cap && as_int(m_cap[c], mk[c]) > as_int(m_peak[k][c], mk[c])) m_peak[k][c] = m_cap[c];
        end
      end
      if (ce || (peak_view != m_vp)) reload = 1'b1;
      view = peak_view;
      m_cp = clr_btn;
      m_vp = peak_view;
    end
`endif
    if (pe) m_page = (m_page + 1) % PAGE_NUM;
    if (reload) for (int k = 0; k < 2; k++) m_seq[k] = build(k, view);
    m_pulse = reload;
    m_pp    = page_btn;
    m_fp    = freeze_btn;
  endtask

  task automatic check_w(input string name, input logic [SEQ_BITS-1:0] act, input logic [SEQ_BITS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_n(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    check_w("seq_signed", seq_out, m_seq[0]);
    check_w("seq_unsigned", seq_out_u, m_seq[1]);
    check_n("pulse", int'(update_pulse), int'(m_pulse));
    check_n("frozen", int'(frozen), int'(m_frz));
    check_n("page", int'(page_idx), m_page);
  endtask

  task automatic step();
    model_step();
    @(posedge sys_clk);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  typedef struct {
    bit              tick, pg, fz;
    logic [IN_W-1:0] ch0;
    logic [19:0]     slot0;
    bit              pulse, frz;
    int              page;
  } vec_t;

  vec_t tbl [16];

  initial begin
    n_checks = 0; n_errors = 0;
    sys_rst_n = 1'b0; probe_in = '0;
    sample_tick = 1'b0; page_btn = 1'b0; freeze_btn = 1'b0; clr_btn = 1'b0; peak_view = 1'b0;
    model_reset();

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 17'd3,     20'd3,      1'b1, 1'b0, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 17'd3,     20'd3,      1'b0, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 17'd5,     20'd5,      1'b1, 1'b1, 0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 17'd9,     20'd5,      1'b0, 1'b1, 0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 17'd9,     20'd5,      1'b0, 1'b1, 0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 17'd9,     20'd5,      1'b0, 1'b1, 0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 17'd9,     20'd5,      1'b0, 1'b1, 0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 17'd9,     20'd5,      1'b0, 1'b0, 0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 17'd9,     20'd9,      1'b1, 1'b0, 0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 17'd11,    20'd11,     1'b1, 1'b0, 0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 17'd12,    20'd12,     1'b1, 1'b1, 0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 17'd13,    20'd12,     1'b0, 1'b1, 0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 17'd13,    20'd0,      1'b1, 1'b0, 1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 17'd13,    20'd0,      1'b0, 1'b0, 1};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 17'd13,    20'd12,     1'b1, 1'b0, 0};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 17'h1FFFF, 20'hFFFFF,  1'b1, 1'b0, 0};

    // Reset state
    repeat (3) @(posedge sys_clk);
    #1;
    check_w("rst_seq", seq_out, '0);
    check_n("rst_page", int'(page_idx), 0);
    check_n("rst_frozen", int'(frozen), 0);
    check_n("rst_pulse", int'(update_pulse), 0);
    sys_rst_n = 1'b1;

    // Idle cycles then first tick: sign vs zero extension of 17'h1FFFF
    step();
    step();
    probe_in[IN_W-1:0] = 17'h1FFFF;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check_n("sx_slot0", int'(seq_out[19:0]), 20'hFFFFF);
    check_n("zx_slot0", int'(seq_out_u[19:0]), 20'h1FFFF);
    check_n("sx_pulse", int'(update_pulse), 1);
    step();
    check_n("sx_pulse_drop", int'(update_pulse), 0);

    // Paging
    for (int c = 0; c < CH_NUM; c++)
      probe_in[c*IN_W +: IN_W] = (c == 7) ? 17'h10000 : 17'(100 * c + 3);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    page_btn = 1'b1;
    step();
    page_btn = 1'b0;
    check_n("pg1_idx", int'(page_idx), 1);
    check_n("pg1_slot0", int'(seq_out[19:0]), 603);
    check_n("pg1_slot1", int'(seq_out[39:20]), 20'hF0000);
    for (int s = 2; s < SLOT_NUM; s++)
      check_n($sformatf("pg1_slot%0d", s), int'(seq_out[s*SEQ_LEN +: SEQ_LEN]), 0);
    step();
    page_btn = 1'b1;
    step();
    page_btn = 1'b0;
    check_n("pg0_idx", int'(page_idx), 0);
    for (int s = 0; s < SLOT_NUM; s++)
      check_n($sformatf("pg0_slot%0d", s), int'(seq_out[s*SEQ_LEN +: SEQ_LEN]), 100 * s + 3);

    // Freeze table
    for (int i = 0; i < 16; i++) begin
      sample_tick = tbl[i].tick;
      page_btn    = tbl[i].pg;
      freeze_btn  = tbl[i].fz;
      probe_in    = '0;
      probe_in[IN_W-1:0] = tbl[i].ch0;
      step();
      check_n($sformatf("tbl%0d_slot0", i), int'(seq_out[19:0]), int'(tbl[i].slot0));
      check_n($sformatf("tbl%0d_pulse", i), int'(update_pulse), int'(tbl[i].pulse));
      check_n($sformatf("tbl%0d_frozen", i), int'(frozen), int'(tbl[i].frz));
      check_n($sformatf("tbl%0d_page", i), int'(page_idx), tbl[i].page);
    end
    sample_tick = 1'b0; page_btn = 1'b0; freeze_btn = 1'b0;

    // Asynchronous reset while FROZEN on page 1
    page_btn = 1'b1;
    step();
    page_btn = 1'b0;
    freeze_btn = 1'b1;
    step();
    freeze_btn = 1'b0;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check_n("pre_rst_frozen", int'(frozen), 1);
    check_n("pre_rst_page", int'(page_idx), 1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_w("arst_seq", seq_out, '0);
    check_n("arst_frozen", int'(frozen), 0);
    check_n("arst_page", int'(page_idx), 0);
    check_n("arst_pulse", int'(update_pulse), 0);
    model_reset();
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    repeat (3) step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check_n("post_rst_pulse", int'(update_pulse), 1);

    // Peak hold
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       probe_in[IN_W-1:0] = 17'd5;
        1:       probe_in[IN_W-1:0] = 17'h1FFFD;
        2:       probe_in[IN_W-1:0] = 17'd9;
        default: probe_in[IN_W-1:0] = 17'd2;
      endcase
      sample_tick = 1'b1;
      step();
    end
    sample_tick = 1'b0;
    peak_view = 1'b1;
    step();
`ifdef DEBUG_PROBE_PEAK_EN
    check_n("peak_slot0", int'(seq_out[19:0]), 9);
`else
    check_n("peak_slot0", int'(seq_out[19:0]), 2);
`endif
    clr_btn = 1'b1;
    step();
    clr_btn = 1'b0;
`ifdef DEBUG_PROBE_PEAK_EN
    check_n("clr_slot0", int'(seq_out[19:0]), 20'hF0000);
`else
    check_n("clr_slot0", int'(seq_out[19:0]), 2);
`endif
    peak_view = 1'b0;
    step();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      sample_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) page_btn   = ~page_btn;
      if ($urandom_range(0, 9) == 0) freeze_btn = ~freeze_btn;
      if ($urandom_range(0, 15) == 0) clr_btn   = ~clr_btn;
      if ($urandom_range(0, 11) == 0) peak_view = ~peak_view;
      for (int c = 0; c < CH_NUM; c++) probe_in[c*IN_W +: IN_W] = IN_W'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/debug_probe_bank.md
DEBUG_PROBE_BANK -- requirements
Module: debug_probe_bank

Interface
REQ-001 SHALL have parameter IN_W, default 17: width of each probe channel.
REQ-002 SHALL have parameter SEQ_LEN, default 20: width of each display slot.
REQ-003 SHALL have parameter CH_NUM, default 8: number of probe channels.
REQ-004 SHALL have parameter SLOT_NUM, default 6: display slots per page.
REQ-005 SHALL have parameter PAGE_W, default 4: page index width.
REQ-006 SHALL have parameter SIGNED_CH, default all ones, CH_NUM bits: bit c=1 sign-extends channel c, 0 zero-extends.
REQ-007 SHALL have port sys_clk, input, 1: the only clock.
REQ-008 SHALL have port sys_rst_n, input, 1: reset, asynchronous, active-low.
REQ-009 SHALL have port probe_in, input, CH_NUM*IN_W: packed channels, channel c at [c*IN_W +: IN_W].
REQ-010 SHALL have port sample_tick, input, 1: one-cycle frame strobe.
REQ-011 SHALL have ports page_btn, freeze_btn and clr_btn, each input, 1: debounced levels.
REQ-012 SHALL have port peak_view, input, 1: level; 1 selects the peak view.
REQ-013 SHALL have port seq_out, output, SLOT_NUM*SEQ_LEN: slot s at [s*SEQ_LEN +: SEQ_LEN].
REQ-014 SHALL have port page_idx, output, PAGE_W: current page.
REQ-015 SHALL have port frozen, output, 1: high in the FROZEN state.
REQ-016 SHALL have port update_pulse, output, 1: one-cycle pulse when seq_out is reloaded.

Function
REQ-017 SHALL register each button level every cycle and form edge = level & ~prev; only edges act.
REQ-018 SHALL define PAGE_NUM = ceil(CH_NUM/SLOT_NUM); SHALL fail elaboration if SEQ_LEN < IN_W or PAGE_NUM > 2^PAGE_W.
REQ-019 SHALL run a three-state FSM: LIVE, FREEZE_PEND, FROZEN.
REQ-020 In LIVE, on sample_tick, SHALL capture all CH_NUM channels into the capture bank in the same cycle.
REQ-021 In LIVE, a freeze edge SHALL move the FSM to FREEZE_PEND.
REQ-022 In FREEZE_PEND, sample_tick SHALL capture once and then move to FROZEN; a freeze edge SHALL cancel back to LIVE.
REQ-023 In FROZEN, the FSM SHALL not capture; a freeze edge SHALL return it to LIVE, and capture SHALL resume at the next sample_tick.
REQ-024 If sample_tick and a freeze edge coincide in LIVE, the capture SHALL happen and the FSM SHALL enter FREEZE_PEND.
REQ-025 A page edge SHALL increment page_idx, wrapping from PAGE_NUM-1 to 0; this SHALL work in every FSM state.
REQ-026 A page edge coinciding with a freeze edge SHALL have both take effect.
REQ-027 Slot s SHALL show channel page_idx*SLOT_NUM+s, extended to SEQ_LEN according to SIGNED_CH.
REQ-028 Slots mapped to a channel index >= CH_NUM SHALL output zero.
REQ-029 seq_out SHALL be registered and reload exactly one cycle after a capture or a page change, with update_pulse high in that same cycle.
REQ-030 If a capture and a page change occur in the same cycle, there SHALL be a single reload and a single pulse.
REQ-031 Between reloads, seq_out SHALL hold its value.
REQ-032 frozen SHALL be high only in FROZEN; FREEZE_PEND SHALL read as 0.

Reset
REQ-033 On sys_rst_n low, the block SHALL asynchronously reset to FSM=LIVE, page_idx=0, capture bank 0, button history 0, seq_out 0, frozen 0 and update_pulse 0.
REQ-034 Assertion mid-FROZEN or mid-FREEZE_PEND SHALL behave identically to reset from LIVE.
REQ-035 After release, the first reload SHALL occur one cycle after the first sample_tick.

Configuration
REQ-036 With macro DEBUG_PROBE_PEAK_EN defined, each capture SHALL also update a per-channel peak: peak = max(peak, captured), compared signed or unsigned per SIGNED_CH.
REQ-037 With DEBUG_PROBE_PEAK_EN, a clr_btn edge SHALL set every peak to its minimum (most negative if signed, 0 if unsigned); reset SHALL apply the same values.
REQ-038 With DEBUG_PROBE_PEAK_EN, peak_view=1 SHALL make slots show peaks instead of captures.
REQ-039 With DEBUG_PROBE_PEAK_EN, a peak_view change or clr_btn edge SHALL count as a reload source (one-cycle latency, update_pulse).
REQ-040 Without DEBUG_PROBE_PEAK_EN, no peak storage SHALL exist, and clr_btn and peak_view SHALL be ignored while the ports remain present.

Verification (CH_NUM=8, SLOT_NUM=6, IN_W=17, SEQ_LEN=20)
REQ-041 SHALL cover: SIGNED_CH bit0=1, ch0=17'h1FFFF, one tick -> next cycle slot0=20'hFFFFF, update_pulse=1; with bit0=0 -> slot0=20'h1FFFF.
REQ-042 SHALL cover: page edge -> page_idx=1, slots0-1 show ch6 and ch7, slots2-5=0; second edge -> page_idx=0, slots show ch0-5.
REQ-043 SHALL cover: ch0=5, freeze edge, tick -> slot0=5, frozen=1; ch0=9 with 3 ticks -> slot0 stays 5 with no pulse; freeze edge then tick -> slot0=9.
REQ-044 SHALL cover: a freeze edge coincident with a tick captures, and the next tick captures again and sets frozen=1; reset asserted while FROZEN -> seq_out=0, frozen=0, page_idx=0.
REQ-045 SHALL cover, with DEBUG_PROBE_PEAK_EN: ch0 ticked with 5, -3, 9, 2 and peak_view=1 -> slot0=9; clr edge -> slot0=20'hF0000; without the macro, the same stimulus -> slot0=2.
